// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite bundle shared by the two master ports and the slave port of the arbiter.
// Valid/ready: a transfer happens on a rising clk edge where both valid and ready are high; once raised, valid and payload hold until then.
interface axi4_lite_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter: one whole transaction at a time, round-robin grants,
// zero-latency pass-through of every channel once a master owns the slave.
module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    axi4_lite_arbiter_if.slave         m0,
    axi4_lite_arbiter_if.slave         m1,
    axi4_lite_arbiter_if.master        s,
    output logic [1:0]                 grant,
    output logic                       busy,
    output logic [2:0]                 state_dbg
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_XFER = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic                    sel;
    logic [ADDR_WIDTH-1:0]   g_awaddr, g_araddr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [DATA_WIDTH/8-1:0] g_wstrb;
    logic                    g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic                    g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
    logic                    req0, req1, pick, pick_wr;

    // Granted master's request side, muxed once and reused by every channel.
    assign sel       = grant_q[1];
    assign g_awaddr  = sel ? m1.awaddr  : m0.awaddr;
    assign g_awvalid = sel ? m1.awvalid : m0.awvalid;
    assign g_wdata   = sel ? m1.wdata   : m0.wdata;
    assign g_wstrb   = sel ? m1.wstrb   : m0.wstrb;
    assign g_wvalid  = sel ? m1.wvalid  : m0.wvalid;
    assign g_bready  = sel ? m1.bready  : m0.bready;
    assign g_araddr  = sel ? m1.araddr  : m0.araddr;
    assign g_arvalid = sel ? m1.arvalid : m0.arvalid;
    assign g_rready  = sel ? m1.rready  : m0.rready;

    assign s.awaddr = g_awaddr;
    assign s.wdata  = g_wdata;
    assign s.wstrb  = g_wstrb;
    assign s.araddr = g_araddr;

    assign m0.awready = g_awready & grant_q[0];
    assign m0.wready  = g_wready  & grant_q[0];
    assign m0.bvalid  = g_bvalid  & grant_q[0];
    assign m0.arready = g_arready & grant_q[0];
    assign m0.rvalid  = g_rvalid  & grant_q[0];
    assign m1.awready = g_awready & grant_q[1];
    assign m1.wready  = g_wready  & grant_q[1];
    assign m1.bvalid  = g_bvalid  & grant_q[1];
    assign m1.arready = g_arready & grant_q[1];
    assign m1.rvalid  = g_rvalid  & grant_q[1];

    assign m0.bresp = s.bresp;
    assign m1.bresp = s.bresp;
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        s.awvalid = 1'b0;
        s.wvalid  = 1'b0;
        s.bready  = 1'b0;
        s.arvalid = 1'b0;
        s.rready  = 1'b0;
        g_awready = 1'b0;
        g_wready  = 1'b0;
        g_bvalid  = 1'b0;
        g_arready = 1'b0;
        g_rvalid  = 1'b0;
        req0      = m0.awvalid | m0.wvalid | m0.arvalid;
        req1      = m1.awvalid | m1.wvalid | m1.arvalid;
        pick      = 1'b0;
        pick_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the master that did not own the last transaction wins.
                pick    = (req0 & req1) ? ~last_q : req1;
                pick_wr = pick ? (m1.awvalid | m1.wvalid) : (m0.awvalid | m0.wvalid);
                if (req0 | req1) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    state_d = pick_wr ? WR_XFER : RD_ADDR;
                end
            end
            WR_XFER: begin
                s.awvalid = g_awvalid & ~aw_done_q;
                g_awready = s.awready & ~aw_done_q;
                s.wvalid  = g_wvalid & ~w_done_q;
                g_wready  = s.wready & ~w_done_q;
                aw_done_d = aw_done_q | (g_awvalid & s.awready);
                w_done_d  = w_done_q | (g_wvalid & s.wready);
                if (aw_done_d & w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s.bready = g_bready;
                g_bvalid = s.bvalid;
                if (s.bvalid & g_bready) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    last_d    = grant_q[1];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            RD_ADDR: begin
                s.arvalid = g_arvalid;
                g_arready = s.arready;
                if (g_arvalid & s.arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s.rready = g_rready;
                g_rvalid = s.rvalid;
                if (s.rvalid & g_rready) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: two scripted masters, a small CSR slave model with a configurable
// B delay, a table of single transactions and hand-written multi-cycle sequences.
module tb_axi4_lite_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_XFER = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    axi4_lite_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    axi4_lite_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    logic [1:0] grant;
    logic       busy;
    logic [2:0] state_dbg;

    axi4_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .grant     (grant),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Master-side signals as arrays so driver tasks can take a master index.
    logic [AW-1:0] m_awaddr[2];
    logic          m_awvalid[2];
    logic [DW-1:0] m_wdata[2];
    logic [3:0]    m_wstrb[2];
    logic          m_wvalid[2];
    logic          m_bready[2];
    logic [AW-1:0] m_araddr[2];
    logic          m_arvalid[2];
    logic          m_rready[2];
    logic          m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
    logic [1:0]    m_bresp[2], m_rresp[2];
    logic [DW-1:0] m_rdata[2];

    assign m0_if.awaddr = m_awaddr[0];  assign m0_if.awvalid = m_awvalid[0];
    assign m0_if.wdata  = m_wdata[0];   assign m0_if.wstrb   = m_wstrb[0];
    assign m0_if.wvalid = m_wvalid[0];  assign m0_if.bready  = m_bready[0];
    assign m0_if.araddr = m_araddr[0];  assign m0_if.arvalid = m_arvalid[0];
    assign m0_if.rready = m_rready[0];
    assign m1_if.awaddr = m_awaddr[1];  assign m1_if.awvalid = m_awvalid[1];
    assign m1_if.wdata  = m_wdata[1];   assign m1_if.wstrb   = m_wstrb[1];
    assign m1_if.wvalid = m_wvalid[1];  assign m1_if.bready  = m_bready[1];
    assign m1_if.araddr = m_araddr[1];  assign m1_if.arvalid = m_arvalid[1];
    assign m1_if.rready = m_rready[1];

    assign m_awready[0] = m0_if.awready;  assign m_awready[1] = m1_if.awready;
    assign m_wready[0]  = m0_if.wready;   assign m_wready[1]  = m1_if.wready;
    assign m_bvalid[0]  = m0_if.bvalid;   assign m_bvalid[1]  = m1_if.bvalid;
    assign m_arready[0] = m0_if.arready;  assign m_arready[1] = m1_if.arready;
    assign m_rvalid[0]  = m0_if.rvalid;   assign m_rvalid[1]  = m1_if.rvalid;
    assign m_bresp[0]   = m0_if.bresp;    assign m_bresp[1]   = m1_if.bresp;
    assign m_rresp[0]   = m0_if.rresp;    assign m_rresp[1]   = m1_if.rresp;
    assign m_rdata[0]   = m0_if.rdata;    assign m_rdata[1]   = m1_if.rdata;

    // ---------------- CSR slave model ----------------
    logic          sl_aw_got, sl_w_got, sl_bvalid, sl_rvalid;
    logic [AW-1:0] sl_addr;
    logic [DW-1:0] sl_data, sl_rdata;
    logic [3:0]    sl_strb;
    int            sl_bcnt;
    int            b_delay = 0;
    logic [DW-1:0] mem[16];

    assign s_if.awready = ~sl_aw_got;
    assign s_if.wready  = ~sl_w_got;
    assign s_if.bvalid  = sl_bvalid;
    assign s_if.bresp   = 2'b00;
    assign s_if.arready = ~sl_rvalid;
    assign s_if.rvalid  = sl_rvalid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.rresp   = 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_aw_got <= 1'b0;
            sl_w_got  <= 1'b0;
            sl_bvalid <= 1'b0;
            sl_rvalid <= 1'b0;
            sl_addr   <= '0;
            sl_data   <= '0;
            sl_strb   <= '0;
            sl_rdata  <= '0;
            sl_bcnt   <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (s_if.awvalid && s_if.awready) begin
                sl_aw_got <= 1'b1;
                sl_addr   <= s_if.awaddr;
            end
            if (s_if.wvalid && s_if.wready) begin
                sl_w_got <= 1'b1;
                sl_data  <= s_if.wdata;
                sl_strb  <= s_if.wstrb;
            end
            if (sl_bvalid) begin
                if (s_if.bready) begin
                    sl_bvalid <= 1'b0;
                    sl_aw_got <= 1'b0;
                    sl_w_got  <= 1'b0;
                    sl_bcnt   <= 0;
                end
            end else if (sl_aw_got && sl_w_got) begin
                if (sl_bcnt < b_delay) begin
                    sl_bcnt <= sl_bcnt + 1;
                end else begin
                    sl_bvalid <= 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (sl_strb[b]) mem[sl_addr[5:2]][8*b +: 8] <= sl_data[8*b +: 8];
                end
            end
            if (sl_rvalid) begin
                if (s_if.rready) sl_rvalid <= 1'b0;
            end else if (s_if.arvalid) begin
                sl_rvalid <= 1'b1;
                sl_rdata  <= mem[s_if.araddr[5:2]];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_write(input int n, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [3:0] strb);
        m_awaddr[n]  = addr;
        m_awvalid[n] = 1'b1;
        m_wdata[n]   = data;
        m_wstrb[n]   = strb;
        m_wvalid[n]  = 1'b1;
        m_bready[n]  = 1'b1;
    endtask

    task automatic wait_write(input int n, input logic [1:0] exp_grant);
        logic aw_hs, w_hs, b_hs;
        bit   done;
        int   cyc;
        done = 0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            aw_hs = m_awvalid[n] && m_awready[n];
            w_hs  = m_wvalid[n] && m_wready[n];
            b_hs  = m_bvalid[n] && m_bready[n];
            if (b_hs) begin
                check("wr_grant", grant, exp_grant);
                check("wr_bresp", m_bresp[n], 2'b00);
            end
            tick();
            cyc++;
            if (aw_hs) m_awvalid[n] = 1'b0;
            if (w_hs) m_wvalid[n] = 1'b0;
            if (b_hs) begin
                m_bready[n] = 1'b0;
                done = 1;
            end
        end
        check("wr_timeout", done, 1);
    endtask

    task automatic start_read(input int n, input logic [AW-1:0] addr);
        m_araddr[n]  = addr;
        m_arvalid[n] = 1'b1;
        m_rready[n]  = 1'b1;
    endtask

    task automatic wait_read(input int n, input logic [1:0] exp_grant, output logic [DW-1:0] data,
                             output int cyc);
        logic ar_hs, r_hs;
        bit   done;
        done = 0;
        cyc  = 0;
        data = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            ar_hs = m_arvalid[n] && m_arready[n];
            r_hs  = m_rvalid[n] && m_rready[n];
            if (r_hs) begin
                data = m_rdata[n];
                check("rd_grant", grant, exp_grant);
                check("rd_rresp", m_rresp[n], 2'b00);
            end
            tick();
            cyc++;
            if (ar_hs) m_arvalid[n] = 1'b0;
            if (r_hs) begin
                m_rready[n] = 1'b0;
                done = 1;
            end
        end
        check("rd_timeout", done, 1);
    endtask

    // ---------------- watchers / grant scoreboard ----------------
    bit watch_sim = 0;
    bit watch_ar0 = 0;
    bit mon_en    = 0;
    logic [1:0] prev_grant = 2'b00;
    int  idle_run   = 0;
    bit  seen_first = 0;
    logic [1:0] got_q[$];
    int  idle_q[$];

    always @(negedge clk) begin
        if (watch_sim && grant == 2'b01) begin
            check("sim_m1_awready_stalled", m_awready[1], 1'b0);
            check("sim_m1_wready_stalled", m_wready[1], 1'b0);
        end
        if (watch_ar0 && (state_dbg == ST_WR_XFER || state_dbg == ST_WR_RESP))
            check("same_m0_arready_held", m_arready[0], 1'b0);
        if (mon_en) begin
            if (grant != 2'b00 && prev_grant == 2'b00) got_q.push_back(grant);
            if (!busy) begin
                idle_run++;
            end else begin
                if (idle_run > 0 && seen_first) idle_q.push_back(idle_run);
                idle_run   = 0;
                seen_first = 1;
            end
            prev_grant = grant;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int          mst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[10];
    logic [1:0] exp_q[$];

    initial begin
        logic [DW-1:0] rd, rd0, rd1;
        int            cyc, c0, c1, k;
        logic [1:0]    eg;
        time           t0, t1;

        tbl[0] = '{0, 1'b1, 32'h00, 32'hAAAAAAAA, 4'hF, 32'h0};
        tbl[1] = '{0, 1'b0, 32'h00, 32'h0,        4'h0, 32'hAAAAAAAA};
        tbl[2] = '{1, 1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[3] = '{1, 1'b1, 32'h04, 32'h12345678, 4'h3, 32'h0};
        tbl[4] = '{0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hFFFF5678};
        tbl[5] = '{1, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 32'h0};
        tbl[6] = '{1, 1'b0, 32'h08, 32'h0,        4'h0, 32'hCAFEF00D};
        tbl[7] = '{0, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hC, 32'h0};
        tbl[8] = '{1, 1'b0, 32'h0C, 32'h0,        4'h0, 32'hDEAD0000};
        tbl[9] = '{1, 1'b0, 32'h00, 32'h0,        4'h0, 32'hAAAAAAAA};

        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0; m_awvalid[i] = 0; m_wdata[i] = '0; m_wstrb[i] = '0;
            m_wvalid[i] = 0; m_bready[i] = 0; m_araddr[i] = '0; m_arvalid[i] = 0; m_rready[i] = 0;
        end

        // Reset state, with requests present that must be ignored.
        m_awvalid[0] = 1'b1;
        m_arvalid[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_m0_awready", m_awready[0], 1'b0);
        check("rst_m1_arready", m_arready[1], 1'b0);
        check("rst_s_awvalid", s_if.awvalid, 1'b0);
        check("rst_s_arvalid", s_if.arvalid, 1'b0);
        m_awvalid[0] = 1'b0;
        m_arvalid[1] = 1'b0;
        rst = 1'b0;
        tick();

        // Simultaneous writes out of reset: m0 first, m1 stalled meanwhile.
        start_write(0, 32'h0, 32'h11111111, 4'hF);
        start_write(1, 32'h0, 32'h22222222, 4'hF);
        watch_sim = 1;
        fork
            begin wait_write(0, 2'b01); t0 = $time; end
            begin wait_write(1, 2'b10); t1 = $time; end
        join
        watch_sim = 0;
        check("sim_order_m0_first", (t0 < t1), 1'b1);
        start_read(0, 32'h0);
        wait_read(0, 2'b01, rd, cyc);
        check("sim_readback", rd, 32'h22222222);

        // Table of isolated transactions.
        for (int i = 0; i < 10; i++) begin
            eg = (tbl[i].mst == 1) ? 2'b10 : 2'b01;
            if (tbl[i].wr) begin
                start_write(tbl[i].mst, tbl[i].addr, tbl[i].data, tbl[i].strb);
                wait_write(tbl[i].mst, eg);
            end else begin
                start_read(tbl[i].mst, tbl[i].addr);
                wait_read(tbl[i].mst, eg, rd, cyc);
                check("tbl_rdata", rd, tbl[i].exp_rd);
                check("tbl_rd_cycles", cyc, 3);
            end
            @(negedge clk);
            check("tbl_idle_busy", busy, 1'b0);
            check("tbl_idle_grant", grant, 2'b00);
            tick();
        end

        // Fairness: 4 back-to-back reads from each master.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2'b01);
            exp_q.push_back(2'b10);
        end
        mon_en = 1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    start_read(0, 32'h0);
                    wait_read(0, 2'b01, rd0, c0);
                    check("fair_m0_data", rd0, 32'hAAAAAAAA);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    start_read(1, 32'h8);
                    wait_read(1, 2'b10, rd1, c1);
                    check("fair_m1_data", rd1, 32'hCAFEF00D);
                end
            end
        join
        mon_en = 0;
        check("fair_grant_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("fair_grant_order", got_q[i], exp_q[i]);
        check("fair_idle_count", idle_q.size(), 7);
        for (int i = 0; i < idle_q.size(); i++)
            check("fair_idle_len", idle_q[i], 1);
        @(negedge clk);
        tick();

        // Split write on m1: AW three cycles ahead of W, slow B; m0 read queued meanwhile.
        b_delay = 5;
        m_awaddr[1] = 32'h10; m_awvalid[1] = 1'b1; m_wdata[1] = 32'h33333333;
        m_wstrb[1] = 4'hF; m_wvalid[1] = 1'b0; m_bready[1] = 1'b0;
        @(negedge clk);
        check("split_idle_grant", grant, 2'b00);
        tick();
        start_read(0, 32'h10);
        m_bready[0] = 1'b1;
        @(negedge clk);
        check("split_grant", grant, 2'b10);
        check("split_s_awvalid", s_if.awvalid, 1'b1);
        check("split_m1_awready", m_awready[1], 1'b1);
        check("split_s_wvalid_idle", s_if.wvalid, 1'b0);
        tick();
        m_awvalid[1] = 1'b0;
        @(negedge clk);
        check("split_aw_done_gates", s_if.awvalid, 1'b0);
        check("split_no_early_b1", m_bvalid[1], 1'b0);
        tick();
        @(negedge clk);
        check("split_no_early_b2", m_bvalid[1], 1'b0);
        check("split_still_xfer", state_dbg, ST_WR_XFER);
        tick();
        m_wvalid[1] = 1'b1;
        @(negedge clk);
        check("split_m1_wready", m_wready[1], 1'b1);
        tick();
        m_wvalid[1] = 1'b0;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            check("split_sbready_gated", s_if.bready, 1'b0);
            check("split_m0_arready_held", m_arready[0], 1'b0);
            if (m_bvalid[1]) break;
            tick();
            k++;
        end
        check("split_bvalid_seen", m_bvalid[1], 1'b1);
        tick();
        m_bready[1] = 1'b1;
        @(negedge clk);
        check("split_sbready_follows", s_if.bready, 1'b1);
        check("split_bvalid_held", m_bvalid[1], 1'b1);
        check("split_grant_at_b", grant, 2'b10);
        tick();
        m_bready[1] = 1'b0;
        m_bready[0] = 1'b0;
        @(negedge clk);
        check("split_turnaround_grant", grant, 2'b00);
        check("split_turnaround_busy", busy, 1'b0);
        wait_read(0, 2'b01, rd, cyc);
        check("split_m0_readback", rd, 32'h33333333);

        // Same master: write and read requested together; write goes first.
        b_delay = 2;
        watch_ar0 = 1;
        start_write(0, 32'h14, 32'h5A5A5A5A, 4'hF);
        start_read(0, 32'h14);
        wait_write(0, 2'b01);
        watch_ar0 = 0;
        wait_read(0, 2'b01, rd, cyc);
        check("same_read_new_data", rd, 32'h5A5A5A5A);

        // Reset while in WR_RESP, then a fresh m1 read.
        b_delay = 5;
        start_write(1, 32'h0, 32'h77777777, 4'hF);
        k = 0;
        while (state_dbg != ST_WR_RESP && k < 50) begin
            tick();
            k++;
        end
        check("mid_reached_wr_resp", state_dbg, ST_WR_RESP);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_s_bready", s_if.bready, 1'b0);
        check("mid_rst_s_awvalid", s_if.awvalid, 1'b0);
        check("mid_rst_m1_bvalid", m_bvalid[1], 1'b0);
        check("mid_rst_m1_awready", m_awready[1], 1'b0);
        m_awvalid[1] = 1'b0;
        m_wvalid[1]  = 1'b0;
        m_bready[1]  = 1'b0;
        b_delay      = 0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        start_read(1, 32'h0);
        wait_read(1, 2'b10, rd, cyc);
        check("post_rst_rdata", rd, 32'h0);
        check("post_rst_rd_cycles", cyc, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi4_lite_arbiter.md
# axi4_lite_arbiter

Two-master, one-slave AXI4-Lite arbiter that shares the CSR register slave between the PS general-purpose port (master 0) and the PL-side configuration sequencer (master 1). It runs one complete transaction at a time: read, or write address + data + response. Grants alternate round-robin between masters. Non-granted masters are stalled with ready low. It sits directly in front of the CSR block, so every CSR access (e.g. CSR_CTRL) passes through it.

## Interface
- ADDR_WIDTH, 32, AXI address width for all ports
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8
- clk  in  1  single clock for all logic
- rst  in  1  reset is asynchronous and active-high
- mN_awaddr/mN_awvalid, mN_awready (N=0,1)  in/in, out  ADDR_WIDTH/1, 1  master write-address channel
- mN_wdata/mN_wstrb/mN_wvalid, mN_wready  in, out  DATA_WIDTH/DATA_WIDTH/8/1, 1  master write-data channel
- mN_bresp/mN_bvalid, mN_bready  out, in  2/1, 1  master write-response channel
- mN_araddr/mN_arvalid, mN_arready  in, out  ADDR_WIDTH/1, 1  master read-address channel
- mN_rdata/mN_rresp/mN_rvalid, mN_rready  out, in  DATA_WIDTH/2/1, 1  master read-data channel
- s_aw*, s_w*, s_b*, s_ar*, s_r*  mirrored  same widths  slave-side copies of the five channels
- grant  out  2  one-hot owner of the current transaction; 00 when idle
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_RESP.
- Request of master N: wr_req = mN_awvalid | mN_wvalid; rd_req = mN_arvalid.
- IDLE arbitration:
  - Choose among masters with any request.
  - On contention, the master not granted last wins. The pointer resets to "master 1 last", so master 0 wins first.
  - Within the chosen master, a write beats a read.
  - Register grant. Go to WR_XFER or RD_ADDR. No slave signal is driven in IDLE.
- WR_XFER:
  - AW and W are forwarded independently and combinationally: s_awvalid = mN_awvalid & !aw_done, and mN_awready = s_awready & !aw_done; W works the same way.
  - aw_done and w_done set on their handshakes.
  - Go to WR_RESP once both are set, including when both complete in the same cycle.
- WR_RESP:
  - Forward s_bvalid/s_bresp to mN and mN_bready to s_bready.
  - On the B handshake: go to IDLE, clear the done flags, update the pointer to N.
- RD_ADDR: forward AR. On the AR handshake, go to RD_RESP.
- RD_RESP: forward R. On the R handshake, go to IDLE and update the pointer.
- Non-granted master: all its ready and valid outputs are 0; its inputs are ignored.
- Slave-side valids are 0 outside the matching state. Slave-side payloads carry the granted master's values; they are don't-care when the valid is low.
- Pending AR of the granted master during a write is held off (arready 0) until a later grant.
- Reset (any state, asynchronous): state IDLE, grant 00, busy 0, done flags 0, pointer "master 1 last", every valid/ready output 0. An in-flight slave transaction is abandoned; the bench must reset the slave together with the arbiter.
- A master dropping valid before its handshake violates AXI. The behaviour is unspecified and has no recovery logic.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k has its slave valid asserted in cycle k+1.
- Data path: pass-through, zero added latency per channel. No registers on payloads or ready paths.
- Turnaround: 1 IDLE cycle between a response handshake and the next grant.
- Minimum write with a zero-wait slave: 3 cycles (IDLE, WR_XFER, WR_RESP). Minimum read: 3 cycles.
- grant and busy are registered and change on the edge that leaves or enters IDLE.

## Test plan
- **Single write/read:** m0 writes CSR_CTRL = 0xAAAAAAAA, wstrb 0xF, then reads it back.
  - Read returns 0xAAAAAAAA with rresp 00.
  - grant = 01 throughout, busy low between transactions.
- **Simultaneous writes:** out of reset, m0 writes 0x11111111 and m1 writes 0x22222222 to CSR_CTRL in the same cycle.
  - m0 is served first, then m1.
  - Final readback is 0x22222222.
  - m1_awready stays 0 during m0's transaction.
- **Fairness:** m0 and m1 issue 4 back-to-back reads each.
  - Grants alternate 01, 10, 01, 10, …
  - Exactly one IDLE cycle between transactions.
- **Split write:** m1 asserts AW 3 cycles before W, with a slave B delay of 5 cycles.
  - s_bready is gated to m1.
  - B reaches m1 only after both AW and W handshakes.
  - m0 read requested meanwhile is granted only after m1's B handshake.
- **Same-master write beats read:** m0 asserts awvalid, wvalid and arvalid together.
  - The write completes first; m0_arready = 0 until the read grant.
  - The read returns the newly written data.
- **Reset mid-transaction:** assert rst while in WR_RESP.
  - Outputs go to reset values asynchronously.
  - After release, a fresh m1 read completes normally with grant 10.
